// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory port arbiter.
// Holds the state encoding and the grant codes driven on the grant port.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    function automatic logic [1:0] gnt_code(input logic pick_d);
        return pick_d ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that did not win last time wins.
module rr_pick2 (
    input  logic i_valid_i,
    input  logic i_valid_d,
    input  logic i_last_d,
    output logic o_pick_i,
    output logic o_pick_d
);

    always_comb begin
        o_pick_i = i_valid_i & (~i_valid_d | i_last_d);
        o_pick_d = i_valid_d & (~i_valid_i | ~i_last_d);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between the I-cache and D-cache with
// round-robin arbitration, response routing and a watchdog abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_valid,
    input  logic              i_req_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] i_req_data,
    output logic              i_req_ready,
    output logic              i_req_err,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_valid,
    input  logic              d_req_wr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic [DATA_W-1:0] d_req_data,
    output logic              d_req_ready,
    output logic              d_req_err,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_wdog;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_valid;
    logic              r_mem_wr;
    logic [1:0]        r_grant;

    logic w_pick_i;
    logic w_pick_d;
    logic w_cpl;
    logic w_abort;

    rr_pick2 u_pick (
        .i_valid_i (i_req_valid),
        .i_valid_d (d_req_valid),
        .i_last_d  (r_last_d),
        .o_pick_i  (w_pick_i),
        .o_pick_d  (w_pick_d)
    );

    // A ready arriving in the timeout cycle wins over the abort.
    always_comb begin
        w_cpl   = (r_state == ARB_BUSY) && mem_req_ready;
        w_abort = (TIMEOUT != 0) && (r_state == ARB_BUSY) && !mem_req_ready &&
                  (r_wdog == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_i || w_pick_d) w_next_state = ARB_BUSY;
            ARB_BUSY: if (w_cpl || w_abort)     w_next_state = ARB_DONE;
            ARB_DONE: w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ARB_IDLE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d    <= 1'b1;
            r_wdog      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_grant     <= GNT_NONE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_i || w_pick_d) begin
                        r_mem_addr  <= w_pick_d ? d_req_addr : i_req_addr;
                        r_mem_wdata <= w_pick_d ? d_wr_data  : i_wr_data;
                        r_mem_wr    <= w_pick_d ? d_req_wr   : i_req_wr;
                        r_mem_valid <= 1'b1;
                        r_grant     <= gnt_code(w_pick_d);
                        r_last_d    <= w_pick_d;
                        r_wdog      <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_cpl || w_abort) begin
                        r_mem_valid <= 1'b0;
                        r_wdog      <= '0;
                        r_grant     <= GNT_NONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        i_req_ready = w_cpl && (r_grant == GNT_I);
        d_req_ready = w_cpl && (r_grant == GNT_D);
        i_req_err   = w_abort && (r_grant == GNT_I);
        d_req_err   = w_abort && (r_grant == GNT_D);
        i_req_data  = i_req_ready ? mem_req_data : '0;
        d_req_data  = d_req_ready ? mem_req_data : '0;
    end

    assign mem_req_addr  = r_mem_addr;
    assign mem_wr_data   = r_mem_wdata;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_wr    = r_mem_wr;
    assign grant         = r_grant;
    assign busy          = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// transactions checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_req_addr = '0, d_req_addr = '0, mem_req_addr;
    logic          i_req_valid = 1'b0, d_req_valid = 1'b0;
    logic          i_req_wr = 1'b0, d_req_wr = 1'b0;
    logic [DW-1:0] i_wr_data = '0, d_wr_data = '0, mem_wr_data;
    logic [DW-1:0] i_req_data, d_req_data;
    logic          i_req_ready, i_req_err, d_req_ready, d_req_err;
    logic          mem_req_valid, mem_req_wr;
    logic [DW-1:0] mem_req_data = '0;
    logic          mem_req_ready = 1'b0;
    logic [1:0]    grant;
    logic          busy;

    int   n_chk = 0;
    int   n_err = 0;
    logic model_last_d;   // model: did D win the most recent arbitration

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_wr(i_req_wr),
        .i_wr_data(i_wr_data), .i_req_data(i_req_data), .i_req_ready(i_req_ready),
        .i_req_err(i_req_err),
        .d_req_addr(d_req_addr), .d_req_valid(d_req_valid), .d_req_wr(d_req_wr),
        .d_wr_data(d_wr_data), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
        .d_req_err(d_req_err),
        .mem_req_addr(mem_req_addr), .mem_wr_data(mem_wr_data),
        .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle. lat = BUSY cycle in which memory
    // answers; anything outside 1..TO means memory never answers.
    task automatic run_txn(input logic vi, input logic vd,
                           input logic [AW-1:0] ia, input logic iw, input logic [DW-1:0] idat,
                           input logic [AW-1:0] da, input logic dw, input logic [DW-1:0] ddat,
                           input int lat, input logic [DW-1:0] rdat,
                           input logic keep_loser, input logic drop_early, input string tag);
        logic wd, cpl, ri, rd, ei, ed;
        int   last_c;
        i_req_valid = vi; i_req_addr = ia; i_req_wr = iw; i_wr_data = idat;
        d_req_valid = vd; d_req_addr = da; d_req_wr = dw; d_wr_data = ddat;
        wd     = vd && (!vi || !model_last_d);
        cpl    = (lat >= 1) && (lat <= TO);
        last_c = cpl ? lat : TO;
        @(posedge clk); #1;
        for (int c = 1; c <= last_c; c++) begin
            mem_req_ready = (c == lat);
            mem_req_data  = (c == lat) ? rdat : DW'($urandom);
            if (drop_early && c == 2) begin
                if (wd) d_req_valid = 1'b0; else i_req_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, ".mem"}, {mem_req_valid, mem_req_wr, grant, busy},
                {1'b1, wd ? dw : iw, wd ? 2'b10 : 2'b01, 1'b1});
            chk({tag, ".addr"}, mem_req_addr, wd ? da : ia);
            chk({tag, ".wdata"}, mem_wr_data, wd ? ddat : idat);
            ri = (c == lat) && !wd;
            rd = (c == lat) && wd;
            ei = !cpl && (c == TO) && !wd;
            ed = !cpl && (c == TO) && wd;
            chk({tag, ".resp"}, {i_req_ready, i_req_err, d_req_ready, d_req_err},
                {ri, ei, rd, ed});
            chk({tag, ".rdata"}, {i_req_data, d_req_data},
                {ri ? rdat : 32'h0, rd ? rdat : 32'h0});
            @(posedge clk); #1;
        end
        // turnaround cycle: a stray ready here must not be forwarded
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_req_data  = DW'($urandom);
        if (wd || !keep_loser) d_req_valid = 1'b0;
        if (!wd || !keep_loser) i_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".done"}, {mem_req_valid, grant, busy}, {1'b0, 2'b00, 1'b1});
        chk({tag, ".done_resp"}, {i_req_ready, i_req_err, d_req_ready, d_req_err}, 4'h0);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk({tag, ".idle"}, {mem_req_valid, grant, busy}, 4'h0);
        model_last_d = wd;
    endtask

    initial begin
        #1;
        chk("reset.mem", {mem_req_valid, mem_req_wr, grant, busy}, 5'h0);
        chk("reset.bus", {mem_req_addr, mem_wr_data}, 64'h0);
        chk("reset.resp", {i_req_ready, i_req_err, d_req_ready, d_req_err}, 4'h0);
        chk("reset.rdata", {i_req_data, d_req_data}, 64'h0);
        #11 rst = 1'b1;
        model_last_d = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 32'h40, 0, 32'h0, 32'h0, 0, 32'h0, 3, 32'hDEAD_BEEF, 0, 0, "i_read");
        run_txn(1, 1, 32'h80, 0, 32'h0, 32'h180, 0, 32'h0, 2, 32'h1111_0001, 1, 0, "tie1");
        run_txn(0, 1, 32'h80, 0, 32'h0, 32'h180, 0, 32'h0, 2, 32'h2222_0002, 0, 0, "tie2");
        run_txn(1, 1, 32'hC0, 0, 32'h0, 32'h1C0, 0, 32'h0, 1, 32'h3333_0003, 0, 0, "tie3");
        run_txn(0, 1, 32'h0, 0, 32'h0, 32'h100, 1, 32'h1234_5678, 4, 32'h0, 0, 0, "d_write");
        run_txn(1, 1, 32'h200, 0, 32'h0, 32'h300, 1, 32'h5555_AAAA, 5, 32'h4444_0004, 1, 0, "hold_i");
        run_txn(0, 1, 32'h200, 0, 32'h0, 32'h300, 1, 32'h5555_AAAA, 2, 32'h0, 0, 0, "hold_d");
        run_txn(1, 0, 32'h400, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, "wdog");
        run_txn(0, 1, 32'h0, 0, 32'h0, 32'h500, 0, 32'h0, TO, 32'h6666_0006, 0, 0, "race");

        // spurious ready while idle
        mem_req_ready = 1'b1; mem_req_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("spur.resp", {i_req_ready, i_req_err, d_req_ready, d_req_err}, 4'h0);
        chk("spur.rdata", {i_req_data, d_req_data}, 64'h0);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("spur.idle", {mem_req_valid, grant, busy}, 4'h0);

        // asynchronous reset in the middle of a transaction
        i_req_valid = 1'b1; i_req_addr = 32'h600; d_req_valid = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mid.mem", {mem_req_valid, grant, busy}, 4'h0);
        chk("rst_mid.resp", {i_req_ready, i_req_err, d_req_ready, d_req_err}, 4'h0);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        model_last_d = 1'b1;
        @(posedge clk); #1;
        run_txn(1, 1, 32'h700, 1, 32'h7777_0007, 32'h800, 0, 32'h0, 2, 32'h0, 0, 0, "post_rst");

        for (int k = 0; k < 40; k++) begin
            logic vi, vd;
            vi = 1'($urandom_range(0, 1));
            vd = vi ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(vi, vd, AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom),
                    AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom),
                    $urandom_range(1, TO + 2), DW'($urandom),
                    vi && vd && 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
